logic_unit_arb: RTL and testbench
=================================

# logic_unit_arb

Shares one registered bitwise logic unit (AND/OR/XOR/NOR) between two requesters, for example the EX stage and a checksum helper. Requests are granted round-robin with valid/ready handshakes. The result is held in a single response register until its owner accepts it. A new request can be accepted in the same cycle as a response handshake, so sustained throughput is one operation per cycle.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a, req0_b  in  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid, rsp1_ready: same as requester 0
- rsp_res  out  WIDTH  result, shared by both response channels, meaningful only while a rsp*_valid is high
- busy  out  1  response register occupied (state RESP)
- op_cnt  out  16  count of completed response handshakes, wraps 0xFFFF→0x0000

## Operation
- FSM states:
  - IDLE: response register empty.
  - RESP: response register holds a result for owner `own`.
- Free condition: `free = (state==IDLE) | rsp_fire`. `rsp_fire` is `rsp<own>_valid & rsp<own>_ready`.
- Arbitration runs only when `free`:
  - If only one reqN_valid is high, it is granted.
  - If both are high, the requester not granted last (pointer `last`) is granted.
  - reqN_ready = free & grant==N. At most one ready is high per cycle.
  - ready depends combinationally on valid and on rsp_ready. Requesters must not make valid depend on ready.
- On accept (reqN_valid & reqN_ready):
  - rsp_res ← op(reqN_a, reqN_b).
  - own ← N, last ← N, state ← RESP.
- On rsp_fire with no accept in the same cycle: state ← IDLE.
- On rsp_fire with an accept in the same cycle: state stays RESP, and the register is loaded with the new result and owner.
- op_cnt increments by 1 on every rsp_fire.
- rspN_valid = (state==RESP) & own==N.
- rsp_res holds its value while stalled: rsp_ready low keeps the result, owner and state unchanged. Both req*_ready stay low in that case.
- Operands are sampled only at the accept edge. Changes to req inputs after acceptance have no effect.
- NOR result = ~(a|b), full WIDTH. No carries, no sign handling.

## Timing
- Reset (async, immediate), while rst is high:
  - state=IDLE, last=1 (requester 0 wins the first contention), own=0.
  - rsp_res=0, op_cnt=0.
  - req*_ready=0, rsp*_valid=0, busy=0.
- First cycle after rst deasserts: req*_ready follow the arbitration rules.
- Latency: accept at edge k gives rspN_valid high and rsp_res valid from edge k onward, i.e. visible in the cycle after the request cycle.
- Back-to-back: with rsp_ready held high and valid requests present, one accept and one response per cycle.
- Simultaneous events:
  - Response handshake with the same requester re-requesting: accepted in the same cycle, no bubble.
  - Contention while one requester's response is being drained: the round-robin pointer decides the grant, not the response owner.
- Reset mid-operation: the pending result is discarded, no rsp_fire is counted, and op_cnt returns to 0.

## Test plan
- Reset, then req0: op=10, a=0xFFFF0000, b=0x0F0F0F0F, rsp0_ready=1.
  - Required: req0_ready=1 in the request cycle.
  - Next cycle: rsp0_valid=1, rsp_res=0xF0F00F0F, op_cnt 0→1.
- Both requesters valid continuously, rsp*_ready=1, ops XOR (req0) and AND (req1).
  - Required: grants alternate 0,1,0,1 one per cycle, starting with 0.
  - Each rsp_res matches its owner's op.
- req0 accepted with rsp0_ready=0 for 5 cycles, req1 valid throughout.
  - Required: req1_ready=0, busy=1, rsp_res stable for those 5 cycles.
  - Then rsp0_ready=1: req1 accepted in that same cycle.
- NOR with a=b=0 → 0xFFFFFFFF. AND with a=0xAAAAAAAA, b=0x55555555 → 0.
- Preload op_cnt to 0xFFFF via 65535 responses, then one more response.
  - Required: op_cnt=0x0000.
- rst asserted mid-cycle while in RESP.
  - Required: rsp*_valid and busy drop immediately without a clock edge.
  - After release, req0 wins the first contention.

Source files
------------

// File: rtl/logic_unit_arb_if.sv
// logic_unit_arb_if: request/response bundle for the shared logic unit.
//   master : requester side (drives req*_valid/op/a/b, rsp*_ready)
//   slave  : arbiter side   (drives req*_ready, rsp*_valid, rsp_res, busy, op_cnt)
interface logic_unit_arb_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             busy;
  logic [15:0]      op_cnt;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_res, busy, op_cnt
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_res, busy, op_cnt
  );
endinterface

// File: rtl/logic_unit_arb.sv
// logic_unit_arb: one registered AND/OR/XOR/NOR unit shared round-robin by
// two requesters, with a single response register.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : logic_unit_arb_if.slave (request/response handshakes, result,
//          busy flag, completed-response counter)
module logic_unit_arb #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  logic_unit_arb_if.slave    bus
);
  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_own, r_last;
  logic [WIDTH-1:0] r_res;
  logic [15:0]      r_cnt;

  logic [1:0]             w_vld, w_rsp_rdy, w_req_rdy, w_rsp_vld;
  logic [1:0][1:0]        w_op;
  logic [1:0][WIDTH-1:0]  w_a, w_b;
  logic                   w_rsp_fire, w_free, w_gnt, w_accept, w_busy;
  logic [WIDTH-1:0]       w_res;

  assign w_vld     = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_op      = {bus.req1_op, bus.req0_op};
  assign w_a       = {bus.req1_a, bus.req0_a};
  assign w_b       = {bus.req1_b, bus.req0_b};

  // The register frees up either when empty or when its owner drains it
  // this cycle, which is what allows one op per cycle back-to-back.
  assign w_rsp_fire = (r_state == S_RESP) & w_rsp_rdy[r_own];
  assign w_free     = (r_state == S_IDLE) | w_rsp_fire;
  // Contention goes to the requester not granted last; otherwise the lone valid.
  assign w_gnt      = (&w_vld) ? ~r_last : w_vld[1];
  assign w_accept   = w_free & (|w_vld);

  always_comb begin
    w_res = '0;
    case (w_op[w_gnt])
      2'b00:   w_res = w_a[w_gnt] & w_b[w_gnt];
      2'b01:   w_res = w_a[w_gnt] | w_b[w_gnt];
      2'b10:   w_res = w_a[w_gnt] ^ w_b[w_gnt];
      default: w_res = ~(w_a[w_gnt] | w_b[w_gnt]);
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state (an accept reloads RESP even while draining)
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)        w_state_nxt = S_RESP;
    else if (w_rsp_fire) w_state_nxt = S_IDLE;
  end

  // FSM: outputs; ready is masked during reset since the comb path would
  // otherwise see IDLE and raise it.
  always_comb begin
    w_req_rdy = '0;
    w_rsp_vld = '0;
    w_busy    = 1'b0;
    if (!rst) begin
      if (w_accept)           w_req_rdy[w_gnt] = 1'b1;
      if (r_state == S_RESP) begin
        w_rsp_vld[r_own] = 1'b1;
        w_busy           = 1'b1;
      end
    end
  end

  // Result register, owner, round-robin pointer and handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res  <= '0;
      r_own  <= 1'b0;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_res  <= w_res;
        r_own  <= w_gnt;
        r_last <= w_gnt;
      end
      if (w_rsp_fire) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.req0_ready = w_req_rdy[0];
  assign bus.req1_ready = w_req_rdy[1];
  assign bus.rsp0_valid = w_rsp_vld[0];
  assign bus.rsp1_valid = w_rsp_vld[1];
  assign bus.rsp_res    = r_res;
  assign bus.busy       = w_busy;
  assign bus.op_cnt     = r_cnt;
endmodule

// File: tb/tb_logic_unit_arb.sv
module tb_logic_unit_arb;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_arb_if #(.WIDTH(W)) bus();

  logic_unit_arb #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         own;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lu_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic sb_pop(input bit n);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_own", {31'd0, n}, {31'd0, e.own});
      chk("sb_res", bus.rsp_res, e.res);
    end
  endtask

  // Scoreboard: drain on response handshakes first, then record new accepts
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp0_valid && bus.rsp0_ready) sb_pop(1'b0);
      if (bus.rsp1_valid && bus.rsp1_ready) sb_pop(1'b1);
      if (bus.req0_valid && bus.req0_ready)
        sb.push_back('{own: 1'b0, res: lu_ref(bus.req0_op, bus.req0_a, bus.req0_b)});
      if (bus.req1_valid && bus.req1_ready)
        sb.push_back('{own: 1'b1, res: lu_ref(bus.req1_op, bus.req1_a, bus.req1_b)});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nedge;
    @(negedge clk);
  endtask

  task automatic clr_in;
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clr_in();
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  // Single request on one channel, drained the following cycle
  task automatic issue(input bit n, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expres);
    if (n) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      bus.req1_valid = 1'b1; bus.rsp1_ready = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      bus.req0_valid = 1'b1; bus.rsp0_ready = 1'b1;
    end
    nedge();
    chk("req_rdy", {31'd0, n ? bus.req1_ready : bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    nedge();
    chk("rsp_vld", {31'd0, n ? bus.rsp1_valid : bus.rsp0_valid}, 32'd1);
    chk("rsp_res", bus.rsp_res, expres);
    tick();
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    // Reset state, with a request pending to prove ready is held low
    bus.req0_valid = 1'b1;
    nedge();
    chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_vld0", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("rst_vld1", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_res",  bus.rsp_res, 32'd0);
    chk("rst_cnt",  {16'd0, bus.op_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b0;

    // Basic XOR, counter 0 -> 1
    issue(1'b0, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
    nedge();
    chk("t1_cnt", {16'd0, bus.op_cnt}, 32'd1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd0);

    // Round-robin under continuous contention, starting with requester 0
    do_reset();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_op = 2'b10; bus.req1_op = 2'b00;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      bus.req1_a = $urandom; bus.req1_b = $urandom;
      nedge();
      chk("rr_g0", {31'd0, bus.req0_ready}, {31'd0, (i % 2) == 0});
      chk("rr_g1", {31'd0, bus.req1_ready}, {31'd0, (i % 2) == 1});
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    nedge();
    tick();

    // Stall: owner 0 holds the register, requester 1 must wait
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    bus.req0_op = 2'b01; bus.req0_a = 32'h12340000; bus.req0_b = 32'h00005678;
    bus.req1_op = 2'b00; bus.req1_a = 32'hFFFF0000; bus.req1_b = 32'h0FF00FF0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    nedge();
    chk("st_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("st_rdy1", {31'd0, bus.req1_ready}, 32'd0);
      chk("st_busy", {31'd0, bus.busy}, 32'd1);
      chk("st_res",  bus.rsp_res, 32'h12345678);
      chk("st_vld0", {31'd0, bus.rsp0_valid}, 32'd1);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    nedge();
    chk("st_acc1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    nedge();
    chk("st_vld1", {31'd0, bus.rsp1_valid}, 32'd1);
    chk("st_res1", bus.rsp_res, 32'h0FF00000);
    tick();

    // Boundary ops
    issue(1'b1, 2'b11, 32'h0, 32'h0, 32'hFFFFFFFF);
    issue(1'b0, 2'b00, 32'hAAAAAAAA, 32'h55555555, 32'h0);

    // Asynchronous reset while RESP is held
    bus.rsp0_ready = 1'b0;
    bus.req0_op = 2'b10; bus.req0_a = 32'h1; bus.req0_b = 32'h3;
    bus.req0_valid = 1'b1;
    nedge();
    tick();
    bus.req0_valid = 1'b0;
    nedge();
    chk("mr_busy_pre", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mr_vld0", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("mr_busy", {31'd0, bus.busy}, 32'd0);
    chk("mr_cnt",  {16'd0, bus.op_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    nedge();
    chk("mr_g0", {31'd0, bus.req0_ready}, 32'd1);
    chk("mr_g1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    nedge();
    tick();

    // op_cnt wrap: accept at edge 1, then one handshake per edge
    do_reset();
    bus.rsp0_ready = 1'b1;
    bus.req0_op = 2'b00; bus.req0_a = 32'hFFFFFFFF; bus.req0_b = 32'hC3C3A5A5;
    bus.req0_valid = 1'b1;
    repeat (65536) tick();
    bus.req0_valid = 1'b0;
    nedge();
    chk("wr_ffff", {16'd0, bus.op_cnt}, 32'h0000FFFF);
    tick();
    nedge();
    chk("wr_zero", {16'd0, bus.op_cnt}, 32'h0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
